// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (master) and its datapath (slave).
// Signal names follow the datapath's existing control-word naming.
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       imem_ready;
    logic       dmem_ready;
    logic       IRWr;
    logic       PCWr;
    logic       PCWrCond;
    logic [1:0] NPCOp;
    logic       RegWr;
    logic       RegDst;
    logic       MemToReg;
    logic [1:0] ALUSrcB;
    logic       ExtOp;
    logic [1:0] ALUOp;
    logic       DMRd;
    logic       DMWr;
    logic       illegal;
    logic       timeout;
    logic [3:0] state;

    modport master (
        input  opcode, zero, imem_ready, dmem_ready,
        output IRWr, PCWr, PCWrCond, NPCOp, RegWr, RegDst, MemToReg,
               ALUSrcB, ExtOp, ALUOp, DMRd, DMWr, illegal, timeout, state
    );

    modport slave (
        output opcode, zero, imem_ready, dmem_ready,
        input  IRWr, PCWr, PCWrCond, NPCOp, RegWr, RegDst, MemToReg,
               ALUSrcB, ExtOp, ALUOp, DMRd, DMWr, illegal, timeout, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore controller for the multicycle datapath: IF -> ID -> EXE/MEM -> WB,
// with memory-ready handshakes and an optional wait timeout.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam bit             TMO_EN  = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_EXE   = 4'd2,
        S_WBALU = 4'd3,
        S_MADDR = 4'd4,
        S_MRD   = 4'd5,
        S_MWR   = 4'd6,
        S_WBMEM = 4'd7,
        S_BR    = 4'd8,
        S_JMP   = 4'd9
    } state_e;

    typedef struct packed {
        logic       pc_wr;
        logic       pc_wr_cond;
        logic [1:0] npc_op;
        logic       reg_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic [1:0] alu_op;
        logic       dm_rd;
        logic       dm_wr;
    } ctrl_t;

    state_e             state_q, state_n;
    logic [5:0]         op_q, op_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    ctrl_t              ctrl_q, ctrl_o;
    logic               waiting, ready, expire, legal;

    // Control word that a state drives for its whole stay; input-qualified terms are added at the outputs.
    function automatic ctrl_t decode(state_e s, logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_ID: begin
                c.alu_src_b = 2'b10;
                c.ext_op    = 1'b1;
            end
            S_EXE: begin
                case (op)
                    OP_R: begin
                        c.alu_src_b = 2'b00;
                        c.alu_op    = 2'b10;
                    end
                    OP_ORI: begin
                        c.alu_src_b = 2'b10;
                        c.ext_op    = 1'b0;
                        c.alu_op    = 2'b11;
                    end
                    default: begin
                        c.alu_src_b = 2'b10;
                        c.ext_op    = 1'b1;
                        c.alu_op    = 2'b00;
                    end
                endcase
            end
            S_WBALU: begin
                c.reg_wr  = 1'b1;
                c.reg_dst = (op == OP_R);
            end
            S_MADDR: begin
                c.alu_src_b = 2'b10;
                c.ext_op    = 1'b1;
                c.alu_op    = 2'b00;
            end
            S_MRD:   c.dm_rd = 1'b1;
            S_MWR:   c.dm_wr = 1'b1;
            S_WBMEM: begin
                c.reg_wr     = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_BR: begin
                c.alu_op     = 2'b01;
                c.pc_wr_cond = 1'b1;
                c.npc_op     = 2'b01;
            end
            S_JMP: begin
                c.pc_wr  = 1'b1;
                c.npc_op = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_n = state_q;
        op_n    = op_q;
        legal   = bus.opcode inside {OP_R, OP_ORI, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
        waiting = (state_q == S_IF) || (state_q == S_MRD) || (state_q == S_MWR);
        ready   = (state_q == S_IF) ? bus.imem_ready : bus.dmem_ready;
        expire  = TMO_EN && waiting && !ready && (cnt_q == TMO_CNT);

        case (state_q)
            S_IF: if (ready) state_n = S_ID;
            S_ID: begin
                op_n = bus.opcode;
                case (bus.opcode)
                    OP_R, OP_ORI, OP_ADDI: state_n = S_EXE;
                    OP_LW, OP_SW:          state_n = S_MADDR;
                    OP_BEQ:                state_n = S_BR;
                    OP_J:                  state_n = S_JMP;
                    default:               state_n = S_IF;
                endcase
            end
            S_EXE:   state_n = S_WBALU;
            S_MADDR: state_n = (op_q == OP_LW) ? S_MRD : S_MWR;
            S_MRD: begin
                if (ready)       state_n = S_WBMEM;
                else if (expire) state_n = S_IF;
            end
            S_MWR:   if (ready || expire) state_n = S_IF;
            default: state_n = S_IF;
        endcase

        // A timed-out fetch re-enters S_IF, so it must restart the count as a fresh entry does.
        if ((state_n != state_q) || expire)
            cnt_n = '0;
        else if (waiting && !ready && (cnt_q != '1))
            cnt_n = cnt_q + 1'b1;
        else
            cnt_n = cnt_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            op_q    <= '0;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_n;
            op_q    <= op_n;
            cnt_q   <= cnt_n;
            ctrl_q  <= decode(state_n, op_n);
        end
    end

    // Reset forces every output low even in the cycle the state register is still being cleared.
    always_comb begin
        ctrl_o       = rst ? '0 : ctrl_q;
        bus.IRWr     = !rst && (state_q == S_IF) && bus.imem_ready;
        bus.PCWr     = ctrl_o.pc_wr || bus.IRWr;
        bus.PCWrCond = ctrl_o.pc_wr_cond;
        bus.NPCOp    = ctrl_o.npc_op;
        bus.RegWr    = ctrl_o.reg_wr;
        bus.RegDst   = ctrl_o.reg_dst;
        bus.MemToReg = ctrl_o.mem_to_reg;
        bus.ALUSrcB  = ctrl_o.alu_src_b;
        bus.ExtOp    = ctrl_o.ext_op;
        bus.ALUOp    = ctrl_o.alu_op;
        bus.DMRd     = ctrl_o.dm_rd && !expire;
        bus.DMWr     = ctrl_o.dm_wr && !expire;
        bus.illegal  = !rst && (state_q == S_ID) && !legal;
        bus.timeout  = !rst && expire;
        bus.state    = rst ? 4'd0 : state_q;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: instruction-level plans expand into expected per-cycle control traces,
// run against a wait-forever instance and a MEM_TIMEOUT=4 instance.
module tb_multicycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef struct packed {
        logic [3:0] state;
        logic       irwr;
        logic       pcwr;
        logic       pcwrcond;
        logic [1:0] npcop;
        logic       regwr;
        logic       regdst;
        logic       memtoreg;
        logic [1:0] alusrcb;
        logic       extop;
        logic [1:0] aluop;
        logic       dmrd;
        logic       dmwr;
        logic       illegal;
        logic       timeout;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [5:0] opcode;
    logic       zero, imem_ready, dmem_ready;

    always #5 clk = ~clk;

    multicycle_ctrl_if if_a ();
    multicycle_ctrl_if if_b ();

    assign if_a.opcode     = opcode;
    assign if_a.zero       = zero;
    assign if_a.imem_ready = imem_ready;
    assign if_a.dmem_ready = dmem_ready;
    assign if_b.opcode     = opcode;
    assign if_b.zero       = zero;
    assign if_b.imem_ready = imem_ready;
    assign if_b.dmem_ready = dmem_ready;

    multicycle_ctrl #(.MEM_TIMEOUT(0), .CNT_W(8)) dut_a (.clk(clk), .rst(rst_a), .bus(if_a.master));
    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut_b (.clk(clk), .rst(rst_b), .bus(if_b.master));

    obs_t obs_a, obs_b;
    assign obs_a = {if_a.state, if_a.IRWr, if_a.PCWr, if_a.PCWrCond, if_a.NPCOp, if_a.RegWr,
                    if_a.RegDst, if_a.MemToReg, if_a.ALUSrcB, if_a.ExtOp, if_a.ALUOp,
                    if_a.DMRd, if_a.DMWr, if_a.illegal, if_a.timeout};
    assign obs_b = {if_b.state, if_b.IRWr, if_b.PCWr, if_b.PCWrCond, if_b.NPCOp, if_b.RegWr,
                    if_b.RegDst, if_b.MemToReg, if_b.ALUSrcB, if_b.ExtOp, if_b.ALUOp,
                    if_b.DMRd, if_b.DMWr, if_b.illegal, if_b.timeout};

    int checks   = 0;
    int failures = 0;

    bit sel_b;      // which instance is running; the other is held in reset
    int tmo;        // timeout of the running instance, 0 = wait forever
    int cyc;
    int abort_at;
    bit aborted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {OP_R, OP_ORI, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
    endfunction

    // One clock cycle: drive inputs, then compare both instances well away from the edge.
    task automatic step(input logic ir, input logic dr, input logic [5:0] op, input obs_t exp,
                        input string tag);
        if (aborted) return;
        if (cyc == abort_at) begin
            @(negedge clk);
            rst_a      = 1'b1;
            rst_b      = 1'b1;
            opcode     = 6'($urandom);
            imem_ready = 1'b1;
            dmem_ready = 1'b1;
            zero       = 1'($urandom);
            #1;
            check("rst_mid", sel_b ? obs_b : obs_a, '0);
            aborted = 1'b1;
            return;
        end
        cyc++;
        @(negedge clk);
        rst_a      = sel_b;
        rst_b      = !sel_b;
        opcode     = op;
        imem_ready = ir;
        dmem_ready = dr;
        zero       = 1'($urandom);
        #1;
        check(tag, sel_b ? obs_b : obs_a, exp);
        check("idle_in_rst", sel_b ? obs_a : obs_b, '0);
    endtask

    task automatic fetch(input int w, input logic [5:0] op);
        obs_t e;
        bit   done;
        int   lim;
        done = 1'b0;
        while (!done && !aborted) begin
            lim = (tmo > 0 && w > tmo) ? tmo : w;
            for (int k = 0; k < lim; k++) begin
                e = '0;
                step(1'b0, 1'($urandom), 6'($urandom), e, "if_wait");
            end
            e = '0;
            if (tmo > 0 && w > tmo) begin
                e.timeout = 1'b1;
                step(1'b0, 1'($urandom), 6'($urandom), e, "if_timeout");
                w = $urandom_range(0, 2);
            end else begin
                e.irwr = 1'b1;
                e.pcwr = 1'b1;
                step(1'b1, 1'($urandom), 6'($urandom), e, "if_fetch");
                done = 1'b1;
            end
        end
    endtask

    // Data-memory access: strobe held while waiting; a timeout drops it and aborts the instruction.
    task automatic mem_access(input int w, input bit rd, output bit timed_out);
        obs_t e;
        int   lim;
        lim       = (tmo > 0 && w > tmo) ? tmo : w;
        timed_out = (tmo > 0 && w > tmo);
        e         = '0;
        e.state   = rd ? 4'd5 : 4'd6;
        e.dmrd    = rd;
        e.dmwr    = !rd;
        for (int k = 0; k < lim; k++)
            step(1'($urandom), 1'b0, 6'($urandom), e, rd ? "mrd_wait" : "mwr_wait");
        if (timed_out) begin
            e.dmrd    = 1'b0;
            e.dmwr    = 1'b0;
            e.timeout = 1'b1;
            step(1'($urandom), 1'b0, 6'($urandom), e, "mem_timeout");
        end else begin
            step(1'($urandom), 1'b1, 6'($urandom), e, rd ? "mrd_done" : "mwr_done");
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input int wi, input int wd, input int abort_cyc);
        obs_t e;
        bit   to;
        cyc      = 0;
        aborted  = 1'b0;
        abort_at = abort_cyc;
        fetch(wi, op);

        e         = '0;
        e.state   = 4'd1;
        e.alusrcb = 2'b10;
        e.extop   = 1'b1;
        e.illegal = !is_legal(op);
        step(1'($urandom), 1'($urandom), op, e, "id");
        if (!is_legal(op)) return;

        // From here on the opcode input is scrambled: the controller must use its latched copy.
        case (op)
            OP_R, OP_ORI, OP_ADDI: begin
                e       = '0;
                e.state = 4'd2;
                if (op == OP_R) begin
                    e.alusrcb = 2'b00;
                    e.aluop   = 2'b10;
                end else if (op == OP_ORI) begin
                    e.alusrcb = 2'b10;
                    e.extop   = 1'b0;
                    e.aluop   = 2'b11;
                end else begin
                    e.alusrcb = 2'b10;
                    e.extop   = 1'b1;
                    e.aluop   = 2'b00;
                end
                step(1'($urandom), 1'($urandom), 6'($urandom), e, "exe");
                e        = '0;
                e.state  = 4'd3;
                e.regwr  = 1'b1;
                e.regdst = (op == OP_R);
                step(1'($urandom), 1'($urandom), 6'($urandom), e, "wbalu");
            end
            OP_LW, OP_SW: begin
                e         = '0;
                e.state   = 4'd4;
                e.alusrcb = 2'b10;
                e.extop   = 1'b1;
                step(1'($urandom), 1'($urandom), 6'($urandom), e, "maddr");
                mem_access(wd, op == OP_LW, to);
                if (op == OP_LW && !to) begin
                    e          = '0;
                    e.state    = 4'd7;
                    e.regwr    = 1'b1;
                    e.memtoreg = 1'b1;
                    step(1'($urandom), 1'($urandom), 6'($urandom), e, "wbmem");
                end
            end
            OP_BEQ: begin
                e          = '0;
                e.state    = 4'd8;
                e.aluop    = 2'b01;
                e.pcwrcond = 1'b1;
                e.npcop    = 2'b01;
                step(1'($urandom), 1'($urandom), 6'($urandom), e, "br");
            end
            default: begin
                e       = '0;
                e.state = 4'd9;
                e.pcwr  = 1'b1;
                e.npcop = 2'b10;
                step(1'($urandom), 1'($urandom), 6'($urandom), e, "jmp");
            end
        endcase
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] ops [7];
        ops = '{OP_R, OP_ORI, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
        if ($urandom_range(0, 7) == 0) return 6'($urandom);
        return ops[$urandom_range(0, 6)];
    endfunction

    task automatic random_run(input int n, input int max_wait);
        int ab;
        for (int i = 0; i < n; i++) begin
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_instr(rand_op(), $urandom_range(0, max_wait), $urandom_range(0, max_wait), ab);
        end
    endtask

    initial begin
        sel_b      = 1'b0;
        tmo        = 0;
        rst_a      = 1'b1;
        rst_b      = 1'b1;
        opcode     = '0;
        zero       = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;

        repeat (2) begin
            @(negedge clk);
            #1;
            check("reset_a", obs_a, '0);
            check("reset_b", obs_b, '0);
        end

        // Wait-forever instance: directed cases first.
        run_instr(OP_R,    0, 0, -1);
        run_instr(OP_LW,   0, 3, -1);
        run_instr(OP_BEQ,  0, 0, -1);
        run_instr(OP_BEQ,  0, 0, -1);
        run_instr(6'b111111, 0, 0, -1);
        run_instr(OP_ORI,  2, 0, -1);
        run_instr(OP_ADDI, 0, 0, -1);
        run_instr(OP_SW,   1, 7, -1);
        run_instr(OP_J,    0, 0, -1);
        run_instr(OP_LW,   0, 5, 4);
        run_instr(OP_SW,   0, 0, 2);
        run_instr(OP_LW,   0, 300, -1);
        random_run(60, 8);

        // MEM_TIMEOUT=4 instance: expiry, ready on the expiry cycle, and a fetch timeout.
        sel_b = 1'b1;
        tmo   = 4;
        run_instr(OP_SW,   0, 10, -1);
        run_instr(OP_LW,   0, 4, -1);
        run_instr(OP_LW,   0, 5, -1);
        run_instr(OP_R,    6, 0, -1);
        run_instr(OP_SW,   4, 4, -1);
        run_instr(OP_ADDI, 5, 0, -1);
        random_run(80, 7);

        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        check("final_rst", obs_b, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
